// File: rtl/mux4_arb_ctrl.sv
// Round-robin requester arbiter and one-entry capture stage around a 4:1 datapath mux.
// Optional per-requester saturating grant counters are enabled with ARB_GNT_CNT_EN.
module mux4_arb_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RST_PTR = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       req_i,
    input  logic [WIDTH-1:0] mux_out_i,
    input  logic             out_ready_i,
    output logic [1:0]       sel_o,
    output logic [3:0]       gnt_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o
`ifdef ARB_GNT_CNT_EN
    ,
    output logic [15:0]      gnt_cnt0_o,
    output logic [15:0]      gnt_cnt1_o,
    output logic [15:0]      gnt_cnt2_o,
    output logic [15:0]      gnt_cnt3_o
`endif
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   last_sel_q;

    logic [SEL_W-1:0]   win;
    logic [SEL_W-1:0]   idx;
    logic               found;
    logic               accept;

    // Rotating priority scan starting at the pointer; first requester found wins.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = ptr_q + SEL_W'(i);
            if (!found && req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Reset also masks the grant so nothing is consumed while the stage is cleared.
    assign accept = found && ((state_q == ST_EMPTY) || out_ready_i) && !rst_i;

    assign sel_o       = accept ? win : last_sel_q;
    assign gnt_o       = accept ? (NREQ'(1) << win) : '0;
    assign out_data_o  = data_q;
    assign out_valid_o = (state_q == ST_FULL);

    // Output stage: EMPTY/FULL tracks out_valid; a new word can load while the old one leaves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            ptr_q      <= SEL_W'(RST_PTR);
            last_sel_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q    <= ST_FULL;
                        data_q     <= mux_out_i;
                        last_sel_q <= win;
                        ptr_q      <= win + SEL_W'(1);
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        data_q     <= mux_out_i;
                        last_sel_q <= win;
                        ptr_q      <= win + SEL_W'(1);
                    end else if (out_ready_i) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef ARB_GNT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NREQ];

    // Saturating count of grants per requester.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (gnt_o[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign gnt_cnt0_o = cnt_q[0];
    assign gnt_cnt1_o = cnt_q[1];
    assign gnt_cnt2_o = cnt_q[2];
    assign gnt_cnt3_o = cnt_q[3];
`endif

endmodule

// File: tb/tb_mux4_arb_ctrl.sv
// Directed bench for mux4_arb_ctrl with a behavioural 4:1 mux closing the sel -> data loop.
module tb_mux4_arb_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] mux_out;
    logic        ready;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic [31:0] out_data;
    logic        out_valid;
`ifdef ARB_GNT_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

    logic [31:0] d [4];
    int          checks;
    int          errors;

    mux4_arb_ctrl #(.WIDTH(32), .RST_PTR(0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .mux_out_i   (mux_out),
        .out_ready_i (ready),
        .sel_o       (sel),
        .gnt_o       (gnt),
        .out_data_o  (out_data),
        .out_valid_o (out_valid)
`ifdef ARB_GNT_CNT_EN
        ,
        .gnt_cnt0_o  (cnt0),
        .gnt_cnt1_o  (cnt1),
        .gnt_cnt2_o  (cnt2),
        .gnt_cnt3_o  (cnt3)
`endif
    );

    always_comb mux_out = d[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy);
        @(negedge clk);
        req   = r;
        ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_sel [5] = '{3, 0, 1, 2, 3};

    initial begin
        checks = 0;
        errors = 0;
        d[0] = 32'd10; d[1] = 32'd100; d[2] = 32'd200; d[3] = 32'd300;
        rst = 1'b1; req = 4'b0; ready = 1'b0;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_sel",   64'(sel),       64'd0);
        chk("rst_gnt",   64'(gnt),       64'd0);

        // Single request from source 2
        @(negedge clk);
        rst = 1'b0; req = 4'b0100; ready = 1'b1;
        #1;
        chk("single_gnt", 64'(gnt), 64'h4);
        chk("single_sel", 64'(sel), 64'd2);
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'd200);

        // All requesting: rotation continues from ptr=3
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1);
            chk("rr_sel", 64'(sel), 64'(exp_sel[i]));
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << exp_sel[i]));
            tick();
            chk("rr_data", 64'(out_data), 64'(d[exp_sel[i]]));
        end

        // Backpressure holds everything
        for (int i = 0; i < 3; i++) begin
            drive(4'b0011, 1'b0);
            chk("bp_gnt",   64'(gnt),       64'd0);
            chk("bp_sel",   64'(sel),       64'd3);
            chk("bp_valid", 64'(out_valid), 64'd1);
            tick();
            chk("bp_data",  64'(out_data),  64'd300);
        end
        drive(4'b0011, 1'b1);
        chk("bp_rel_gnt", 64'(gnt), 64'h1);
        chk("bp_rel_sel", 64'(sel), 64'd0);
        tick();
        chk("bp_rel_valid", 64'(out_valid), 64'd1);
        chk("bp_rel_data",  64'(out_data),  64'd10);

        drive(4'b0011, 1'b1);
        chk("nxt_gnt", 64'(gnt), 64'h2);
        tick();
        chk("nxt_data", 64'(out_data), 64'd100);

        // Pointer at 2 wraps past 3 back to 0
        drive(4'b0011, 1'b1);
        chk("wrap_gnt", 64'(gnt), 64'h1);
        chk("wrap_sel", 64'(sel), 64'd0);
        tick();
        chk("wrap_data", 64'(out_data), 64'd10);

        // Drain
        drive(4'b0000, 1'b1);
        chk("drain_gnt", 64'(gnt), 64'd0);
        chk("drain_sel", 64'(sel), 64'd0);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_data",  64'(out_data),  64'd10);

        // Empty stage accepts even with ready low, then stalls
        drive(4'b1000, 1'b0);
        chk("empty_gnt", 64'(gnt), 64'h8);
        chk("empty_sel", 64'(sel), 64'd3);
        tick();
        chk("empty_valid", 64'(out_valid), 64'd1);
        chk("empty_data",  64'(out_data),  64'd300);
        drive(4'b1000, 1'b0);
        chk("stall_gnt", 64'(gnt), 64'd0);
        tick();
        chk("stall_data", 64'(out_data), 64'd300);

        drive(4'b0010, 1'b1);
        chk("pre_rst_gnt", 64'(gnt), 64'h2);
        tick();
        chk("pre_rst_data", 64'(out_data), 64'd100);

        // Asynchronous reset mid-traffic, ptr was 2
        @(negedge clk);
        req = 4'b1111; ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_sel",   64'(sel),       64'd0);
        chk("arst_gnt",   64'(gnt),       64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_sel", 64'(sel), 64'd0);
        chk("post_rst_gnt", 64'(gnt), 64'h1);
        tick();
        chk("post_rst_data", 64'(out_data), 64'd10);

`ifdef ARB_GNT_CNT_EN
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            req = 4'b0010; ready = 1'b1;
        end
        tick();
        chk("cnt1_sat", 64'(cnt1), 64'hFFFF);
        chk("cnt0",     64'(cnt0), 64'd1);
        chk("cnt2",     64'(cnt2), 64'd0);
        chk("cnt3",     64'(cnt3), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
